// File: rtl/elevator_ctrl_if.sv
// Elevator controller bus: button pulses and des_compute results in,
// latched requests and car status out.
interface elevator_ctrl_if;
    logic [5:0] input_in_btn;   // car-button pulses, bit k = floor k+1
    logic [9:0] input_out_btn;  // hall-call pulses, F1 up .. F6 down
    logic [2:0] input_des;      // target floor from des_compute
    logic       input_bool;     // des_compute has a target
    logic [5:0] output_in;      // latched car requests
    logic [9:0] output_out;     // latched hall calls
    logic [2:0] output_now;     // current floor 1..6
    logic       output_dir;     // 1 = up, 0 = down
    logic       output_door;    // door open
    logic       output_moving;  // car between floors
    logic [1:0] output_state;   // 0 IDLE, 1 MOVE, 2 CHECK, 3 DOOR

    // Stimulus / des_compute side
    modport master (
        output input_in_btn, input_out_btn, input_des, input_bool,
        input  output_in, output_out, output_now, output_dir,
               output_door, output_moving, output_state
    );

    // Controller side
    modport slave (
        input  input_in_btn, input_out_btn, input_des, input_bool,
        output output_in, output_out, output_now, output_dir,
               output_door, output_moving, output_state
    );
endinterface

// File: rtl/elevator_ctrl.sv
// Six-floor elevator controller. Latches car and hall requests, moves the
// car one floor per MOVE_CYCLES toward the target supplied by an external
// des_compute block, stops at served floors and holds the door open.
module elevator_ctrl #(
    parameter int MOVE_CYCLES = 100,
    parameter int DOOR_CYCLES = 200
) (
    input logic            clk,
    input logic            rst,
    elevator_ctrl_if.slave bus
);

    localparam int MT_W = (MOVE_CYCLES > 1) ? $clog2(MOVE_CYCLES) : 1;
    localparam int DT_W = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [MT_W-1:0] MOVE_LAST = MT_W'(MOVE_CYCLES - 1);
    localparam logic [DT_W-1:0] DOOR_LAST = DT_W'(DOOR_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MOVE  = 2'd1,
        S_CHECK = 2'd2,
        S_DOOR  = 2'd3
    } state_t;

    state_t          state;
    logic [MT_W-1:0] move_cnt;
    logic [DT_W-1:0] door_cnt;
    logic [5:0]      in_q;
    logic [9:0]      out_q;
    logic [2:0]      now_q;
    logic            dir_q;
    logic            door_q;
    logic            moving_q;

    // Car-button bit for floor f (1..6).
    function automatic logic [5:0] car_mask(input logic [2:0] f);
        logic [5:0] m;
        m = '0;
        for (int k = 1; k <= 6; k++)
            if (f == 3'(k)) m[k-1] = 1'b1;
        return m;
    endfunction

    // Hall "up" bit for floor f; floors 1..5 only.
    function automatic logic [9:0] up_mask(input logic [2:0] f);
        logic [9:0] m;
        m = '0;
        for (int k = 1; k <= 5; k++)
            if (f == 3'(k)) m[2*k-2] = 1'b1;
        return m;
    endfunction

    // Hall "down" bit for floor f; floors 2..6 only.
    function automatic logic [9:0] dn_mask(input logic [2:0] f);
        logic [9:0] m;
        m = '0;
        for (int k = 2; k <= 6; k++)
            if (f == 3'(k)) m[2*k-3] = 1'b1;
        return m;
    endfunction

    logic [5:0] here_car, in_clr, in_blk, in_nxt;
    logic [9:0] here_up, here_dn, here_dir, here_opp;
    logic [9:0] out_clr, out_blk, out_nxt;
    logic       des_here, stop_here, enter_door, door_press;

    // Stop decision, request clear/block masks and next request vectors.
    // NOTE: every signal gets an unconditional value first so no path
    // through this block can leave one unassigned and infer a latch.
    always_comb begin
        here_car   = car_mask(now_q);
        here_up    = up_mask(now_q);
        here_dn    = dn_mask(now_q);
        here_dir   = dir_q ? here_up : here_dn;
        here_opp   = dir_q ? here_dn : here_up;
        des_here   = (bus.input_des == now_q);
        stop_here  = (|(in_q & here_car)) || (|(out_q & here_dir)) || des_here;
        enter_door = ((state == S_IDLE) && bus.input_bool && des_here)
                  || ((state == S_CHECK) && stop_here);
        door_press = (|(bus.input_in_btn & here_car))
                  || (|(bus.input_out_btn & (here_up | here_dn)));
        in_clr     = '0;
        out_clr    = '0;
        in_blk     = '0;
        out_blk    = '0;
        if (enter_door) begin
            in_clr  = here_car;
            out_clr = here_dir | (des_here ? here_opp : '0);
        end
        // Presses at the open floor are swallowed; they only hold the door.
        if (state == S_DOOR) begin
            in_blk  = here_car;
            out_blk = here_up | here_dn;
        end
        // A new press wins over a same-cycle clear.
        in_nxt  = (in_q  & ~in_clr)  | (bus.input_in_btn  & ~in_blk);
        out_nxt = (out_q & ~out_clr) | (bus.input_out_btn & ~out_blk);
    end

    // Controller FSM with registered status outputs and request latches.
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            move_cnt <= '0;
            door_cnt <= '0;
            in_q     <= '0;
            out_q    <= '0;
            now_q    <= 3'd1;
            dir_q    <= 1'b1;
            door_q   <= 1'b0;
            moving_q <= 1'b0;
        end else begin
            in_q  <= in_nxt;
            out_q <= out_nxt;
            case (state)
                S_IDLE: begin
                    if (enter_door) begin
                        state    <= S_DOOR;
                        door_q   <= 1'b1;
                        door_cnt <= '0;
                    end else if (bus.input_bool) begin
                        dir_q    <= (bus.input_des > now_q);
                        move_cnt <= '0;
                        moving_q <= 1'b1;
                        state    <= S_MOVE;
                    end
                end
                S_MOVE: begin
                    if (move_cnt == MOVE_LAST) begin
                        moving_q <= 1'b0;
                        state    <= S_CHECK;
                        if (dir_q) begin
                            if (now_q < 3'd6)  now_q <= now_q + 3'd1;
                            if (now_q >= 3'd5) dir_q <= 1'b0;
                        end else begin
                            if (now_q > 3'd1)  now_q <= now_q - 3'd1;
                            if (now_q <= 3'd2) dir_q <= 1'b1;
                        end
                    end else begin
                        move_cnt <= move_cnt + MT_W'(1);
                    end
                end
                S_CHECK: begin
                    if (enter_door) begin
                        state    <= S_DOOR;
                        door_q   <= 1'b1;
                        door_cnt <= '0;
                    end else if (!bus.input_bool) begin
                        state <= S_IDLE;
                    end else begin
                        move_cnt <= '0;
                        moving_q <= 1'b1;
                        state    <= S_MOVE;
                    end
                end
                S_DOOR: begin
                    if (door_press) begin
                        door_cnt <= '0;
                    end else if (door_cnt == DOOR_LAST) begin
                        door_cnt <= '0;
                        door_q   <= 1'b0;
                        state    <= S_IDLE;
                    end else begin
                        door_cnt <= door_cnt + DT_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.output_in     = in_q;
    assign bus.output_out    = out_q;
    assign bus.output_now    = now_q;
    assign bus.output_dir    = dir_q;
    assign bus.output_door   = door_q;
    assign bus.output_moving = moving_q;
    assign bus.output_state  = state;

endmodule

// File: tb/tb_elevator_ctrl.sv
// Scoreboard bench for elevator_ctrl. Stimulus pushes the expected car
// status for every door opening; a monitor pops and compares on each
// rising edge of output_door. A simple des_compute stand-in closes the loop.
module tb_elevator_ctrl;

    localparam int MC = 4;
    localparam int DC = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;

    elevator_ctrl_if bus ();

    elevator_ctrl #(.MOVE_CYCLES(MC), .DOOR_CYCLES(DC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] now;
        logic       dir;
        logic [5:0] in_req;
        logic [9:0] out_req;
    } door_exp_t;

    door_exp_t exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int max_now  = 0;
    logic door_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    // des_compute stand-in: farthest pending floor in the travel direction,
    // else farthest in the other direction, else the current floor.
    logic [6:1] tb_req;
    int         tb_target;
    always_comb begin
        tb_req    = '0;
        tb_target = 0;
        for (int f = 1; f <= 6; f++) tb_req[f] = bus.output_in[f-1];
        for (int f = 1; f <= 5; f++) if (bus.output_out[2*f-2]) tb_req[f] = 1'b1;
        for (int f = 2; f <= 6; f++) if (bus.output_out[2*f-3]) tb_req[f] = 1'b1;
        if (bus.output_dir) begin
            for (int f = 1; f <= 6; f++) if (f > int'(bus.output_now) && tb_req[f]) tb_target = f;
            if (tb_target == 0)
                for (int f = 6; f >= 1; f--) if (f < int'(bus.output_now) && tb_req[f]) tb_target = f;
        end else begin
            for (int f = 6; f >= 1; f--) if (f < int'(bus.output_now) && tb_req[f]) tb_target = f;
            if (tb_target == 0)
                for (int f = 1; f <= 6; f++) if (f > int'(bus.output_now) && tb_req[f]) tb_target = f;
        end
        if (tb_target == 0 && bus.output_now >= 3'd1 && bus.output_now <= 3'd6 && tb_req[bus.output_now])
            tb_target = int'(bus.output_now);
        bus.input_des  = 3'(tb_target);
        bus.input_bool = |tb_req;
    end

    // Monitor: compare car status against the scoreboard whenever the door opens.
    always @(negedge clk) begin
        if (int'(bus.output_now) > max_now) max_now <= int'(bus.output_now);
        if (bus.output_door && !door_prev) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL door_unexpected: door opened at floor %0d, no opening expected", bus.output_now);
            end else begin
                check("door_event(now,dir,in,out)",
                      32'({bus.output_now, bus.output_dir, bus.output_in, bus.output_out}),
                      32'(exp_q.pop_front()));
            end
        end
        door_prev <= bus.output_door;
    end

    task automatic pulse(input logic [5:0] car, input logic [9:0] hall);
        @(negedge clk);
        bus.input_in_btn  = car;
        bus.input_out_btn = hall;
        @(negedge clk);
        bus.input_in_btn  = '0;
        bus.input_out_btn = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_door(input int budget, output int n);
        n = 0;
        while (!bus.output_door && n < budget) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic door_len(output int len);
        len = 0;
        while (bus.output_door && len < 100) begin
            len++;
            @(negedge clk);
        end
    endtask

    task automatic wait_settled(input string name);
        int n;
        n = 0;
        while (!(bus.output_state == 2'd0 && !bus.output_door && !bus.input_bool) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({name, "_settle_in_budget"}, 32'(n < 300), 32'(1));
        check({name, "_doors_all_seen"}, 32'(exp_q.size()), 32'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, k, len;
        bus.input_in_btn  = '0;
        bus.input_out_btn = '0;

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_state",  32'(bus.output_state),  32'(0));
        check("rst_now",    32'(bus.output_now),    32'(1));
        check("rst_dir",    32'(bus.output_dir),    32'(1));
        check("rst_door",   32'(bus.output_door),   32'(0));
        check("rst_moving", 32'(bus.output_moving), 32'(0));
        check("rst_in",     32'(bus.output_in),     32'(0));
        check("rst_out",    32'(bus.output_out),    32'(0));

        // Car call F3 from F1: two floors of MC+1 cycles, then DC door cycles
        exp_q.push_back('{now: 3'd3, dir: 1'b1, in_req: 6'd0, out_req: 10'd0});
        pulse(6'b000100, 10'd0);
        @(negedge clk);
        check("A_move_state", 32'(bus.output_state),  32'(1));
        check("A_moving",     32'(bus.output_moving), 32'(1));
        repeat (4) @(negedge clk);
        check("A_check_now",    32'(bus.output_now),    32'(2));
        check("A_check_state",  32'(bus.output_state),  32'(2));
        check("A_check_moving", 32'(bus.output_moving), 32'(0));
        wait_door(40, k);
        check("A_door_latency", 32'(5 + k), 32'(11));
        door_len(len);
        check("A_door_len",   32'(len),              32'(DC));
        check("A_idle_state", 32'(bus.output_state), 32'(0));
        check("A_idle_now",   32'(bus.output_now),   32'(3));
        check("A_idle_in",    32'(bus.output_in),    32'(0));
        wait_settled("A");

        // Hall F2 down only: target equals floor, both F2 hall bits clear
        do_reset();
        exp_q.push_back('{now: 3'd2, dir: 1'b1, in_req: 6'd0, out_req: 10'd0});
        pulse(6'd0, 10'b0000000010);
        wait_settled("F2dn");

        // Car F5 + F3 up: stop at F3 on the way up, then F5
        do_reset();
        exp_q.push_back('{now: 3'd3, dir: 1'b1, in_req: 6'b010000, out_req: 10'd0});
        exp_q.push_back('{now: 3'd5, dir: 1'b1, in_req: 6'd0,      out_req: 10'd0});
        pulse(6'b010000, 10'b0000010000);
        wait_settled("B");

        // Car F5 + F3 down: pass F3 going up, serve it on the way down
        do_reset();
        exp_q.push_back('{now: 3'd5, dir: 1'b1, in_req: 6'd0, out_req: 10'b0000001000});
        exp_q.push_back('{now: 3'd3, dir: 1'b0, in_req: 6'd0, out_req: 10'd0});
        pulse(6'b010000, 10'b0000001000);
        wait_settled("C");

        // Door at F2: same-floor presses on door cycle 3 restart the timer
        do_reset();
        exp_q.push_back('{now: 3'd2, dir: 1'b1, in_req: 6'd0, out_req: 10'd0});
        pulse(6'b000010, 10'd0);
        wait_door(40, k);
        check("D_door_latency", 32'(k), 32'(6));
        @(negedge clk);
        pulse(6'b000010, 10'b0000000100);
        check("D_in_not_latched",  32'(bus.output_in),   32'(0));
        check("D_out_not_latched", 32'(bus.output_out),  32'(0));
        check("D_door_still_open", 32'(bus.output_door), 32'(1));
        door_len(len);
        check("D_door_restart_len", 32'(len),              32'(DC));
        check("D_idle_state",       32'(bus.output_state), 32'(0));
        wait_settled("D");

        // Top floor: direction forced down, floor saturates at 6
        do_reset();
        exp_q.push_back('{now: 3'd6, dir: 1'b0, in_req: 6'd0, out_req: 10'd0});
        pulse(6'b100000, 10'd0);
        wait_settled("E");
        check("E_dir_at_top", 32'(bus.output_dir), 32'(0));
        exp_q.push_back('{now: 3'd6, dir: 1'b0, in_req: 6'd0, out_req: 10'd0});
        pulse(6'b100000, 10'd0);
        wait_settled("E_reopen");
        check("E_now_at_top",    32'(bus.output_now), 32'(6));
        check("E_max_floor_le6", 32'(max_now <= 6),   32'(1));

        // Reset mid-MOVE with F4/F6 pending aborts and drops requests
        do_reset();
        pulse(6'b101000, 10'b0001000000);
        repeat (2) @(negedge clk);
        check("F_moving_before_rst", 32'(bus.output_state), 32'(1));
        rst = 1'b1;
        @(negedge clk);
        check("F_rst_state",  32'(bus.output_state),  32'(0));
        check("F_rst_now",    32'(bus.output_now),    32'(1));
        check("F_rst_in",     32'(bus.output_in),     32'(0));
        check("F_rst_out",    32'(bus.output_out),    32'(0));
        check("F_rst_door",   32'(bus.output_door),   32'(0));
        check("F_rst_moving", 32'(bus.output_moving), 32'(0));
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("F_stays_idle", 32'(bus.output_state), 32'(0));
        check("F_stays_f1",   32'(bus.output_now),   32'(1));
        check("F_no_doors_pending", 32'(exp_q.size()), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/elevator_ctrl.md
ELEVATOR_CTRL -- requirements
Module: elevator_ctrl

Interface
REQ-001 Parameter MOVE_CYCLES, default 100, clock cycles to travel one floor.
REQ-002 Parameter DOOR_CYCLES, default 200, clock cycles the door stays open.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 input_in_btn  input  6  car-button press pulses; bit k = floor k+1.
REQ-006 input_out_btn  input  10  hall-call pulses; bit 0 = F1 up, 1 = F2 down, 2 = F2 up, 3 = F3 down, 4 = F3 up, 5 = F4 down, 6 = F4 up, 7 = F5 down, 8 = F5 up, 9 = F6 down.
REQ-007 input_des  input  3  target floor from the external des_compute instance, valid 1..6.
REQ-008 input_bool  input  1  des_compute valid flag: 1 = a target exists.
REQ-009 output_in  output  6  latched car requests; drives des_compute input_in.
REQ-010 output_out  output  10  latched hall calls; drives des_compute input_out.
REQ-011 output_now  output  3  current floor, 1..6; drives des_compute input_now.
REQ-012 output_dir  output  1  travel direction, 1 = up, 0 = down; drives des_compute input_dir.
REQ-013 output_door  output  1  door open.
REQ-014 output_moving  output  1  car between floors.
REQ-015 output_state  output  2  FSM state: 0 IDLE, 1 MOVE, 2 CHECK, 3 DOOR.

Function
REQ-016 Each cycle, every request register SHALL set (OR) on a 1 on its pulse input; set SHALL win over a same-cycle clear, except as stated in REQ-024.
REQ-017 IDLE: if input_bool = 0, remain; if input_des = output_now, go to DOOR; otherwise set output_dir = (input_des > output_now), clear the move timer and go to MOVE.
REQ-018 MOVE: output_moving = 1; the move timer SHALL count to MOVE_CYCLES-1, then increment (dir = 1) or decrement (dir = 0) output_now and go to CHECK; a departing IDLE->MOVE->CHECK transit SHALL take exactly MOVE_CYCLES+1 cycles from leaving IDLE.
REQ-019 CHECK (one cycle, output_moving = 0): stop and go to DOOR if output_in[now] is set, or the hall call at now matching output_dir is set, or input_des = output_now; otherwise go to IDLE if input_bool = 0; otherwise go to MOVE with the timer cleared.
REQ-020 output_now SHALL saturate at 1..6; at floor 6, output_dir SHALL be forced to 0; at floor 1, output_dir SHALL be forced to 1.
REQ-021 On entry to DOOR, the controller SHALL clear output_in bit for now and the hall call at now in output_dir.
REQ-022 If input_des = output_now on DOOR entry, the controller SHALL also clear the opposite-direction hall call at now.
REQ-023 DOOR: output_door = 1 for DOOR_CYCLES cycles, then go to IDLE with output_door = 0.
REQ-024 During DOOR, a press of the car button or of either hall call at the current floor SHALL NOT be latched and SHALL restart the door timer.
REQ-025 Requests for other floors SHALL latch normally in every state.
REQ-026 The move and door timers SHALL be wide enough for their parameter value; both parameters SHALL be >= 1.

Reset
REQ-027 While rst = 1 at a clock edge, the block SHALL load: state IDLE, output_now = 1, output_dir = 1, output_door = 0, output_moving = 0, all request registers 0, timers 0.
REQ-028 Reset asserted mid-MOVE or mid-DOOR SHALL abort immediately, with no floor update, and discard all pending requests.

Verification (bench: MOVE_CYCLES = 4, DOOR_CYCLES = 6, real des_compute in loop)
REQ-029 Reset, then pulse input_in_btn = 000100 -> MOVE up, output_now reaches 3 after 2x(4+1) cycles, DOOR for 6 cycles, output_in = 0, back in IDLE at floor 3.
REQ-030 Start at F1, pulse car F5 and hall bit 4 (F3 up) -> stops at F3 (DOOR, bit 4 cleared), then continues to F5.
REQ-031 Start at F1, car F5 plus hall bit 3 (F3 down) -> passes F3 without stopping; bit 3 stays set until served on the down run.
REQ-032 At F2 in DOOR, pulse car bit 1 on cycle 3 -> output_in unchanged and door stays open for 6 more cycles.
REQ-033 Pulse car F6 and travel to F6 -> output_dir forced to 0, output_now never exceeds 6.
REQ-034 Assert rst during MOVE with pending F4 and F6 -> next cycle: IDLE, output_now = 1, all requests 0, door closed.
